// File: rtl/mem_pipe.sv
// Single-port synchronous word memory with a valid/ready request port,
// per-byte write enables and a configurable read-latency pipeline.
// After reset, or when clear is pulsed, a sweep writes INIT_VALUE to every
// word, one word per cycle, before requests are accepted again.
module mem_pipe #(
   parameter int                  WORD_SIZE    = 16,
   parameter int                  MEM_SIZE     = 32,
   parameter int                  ADDR_SIZE    = 5,
   parameter int                  READ_LATENCY = 2,
   parameter logic [WORD_SIZE-1:0] INIT_VALUE  = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_SIZE-1:0]   req_addr,
   input  logic [WORD_SIZE-1:0]   req_wdata,
   input  logic [WORD_SIZE/8-1:0] req_be,
   output logic                   rsp_valid,
   output logic [WORD_SIZE-1:0]   rsp_data,
   output logic                   rsp_err,
   output logic                   init_done
);

   localparam int NBYTES = WORD_SIZE / 8;
   // One extra bit so MEM_SIZE == 2**ADDR_SIZE is still representable.
   localparam logic [ADDR_SIZE:0]   MEM_LIMIT = (ADDR_SIZE + 1)'(MEM_SIZE);
   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_SIZE - 1);

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ADDR_SIZE-1:0]   sweep_addr;
   logic                   sweep_last;
   logic                   accept;
   logic                   in_range;
   logic                   wr_fire;
   logic                   rd_fire;
   logic                   pipe_empty;
   logic [WORD_SIZE-1:0]   rd_word;

   logic [WORD_SIZE-1:0]   bank [MEM_SIZE];

   // Read pipeline: index 0 is loaded at the accept edge, the last index
   // drives the response outputs.
   logic [READ_LATENCY-1:0] vld_p;
   logic [READ_LATENCY-1:0] err_p;
   logic [WORD_SIZE-1:0]    data_p [READ_LATENCY];

   function automatic logic [WORD_SIZE-1:0] merge_bytes(
      input logic [WORD_SIZE-1:0] old_word,
      input logic [WORD_SIZE-1:0] new_word,
      input logic [NBYTES-1:0]    be
   );
      logic [WORD_SIZE-1:0] merged;
      merged = old_word;
      for (int i = 0; i < NBYTES; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

   // Ready and init_done come straight from the state register.
   assign req_ready  = (state == RUN);
   assign init_done  = (state == RUN);
   assign accept     = req_valid & req_ready;
   assign in_range   = ({1'b0, req_addr} < MEM_LIMIT);
   assign wr_fire    = accept & req_write & in_range;
   assign rd_fire    = accept & ~req_write;
   assign pipe_empty = ~|vld_p;
   assign sweep_last = (sweep_addr == LAST_ADDR);
   // Out-of-range reads return zero rather than touching the array.
   assign rd_word    = in_range ? bank[req_addr] : '0;

   assign rsp_valid  = vld_p[READ_LATENCY-1];
   assign rsp_data   = data_p[READ_LATENCY-1];
   assign rsp_err    = err_p[READ_LATENCY-1];

   // State register; reset always restarts the sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= CLEAR;
      else        state <= state_nxt;
   end

   // Next-state logic: sweep -> run -> (clear) drain reads -> sweep.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (sweep_last) state_nxt = RUN;
         RUN:     if (clear)      state_nxt = DRAIN;
         DRAIN:   if (pipe_empty) state_nxt = CLEAR;
         default: state_nxt = CLEAR;
      endcase
   end

   // Sweep address: walks the array in CLEAR, parked at zero otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sweep_addr <= '0;
      end else if (state == CLEAR) begin
         sweep_addr <= sweep_last ? '0 : sweep_addr + 1'b1;
      end else begin
         sweep_addr <= '0;
      end
   end

   // Array write port: sweep writes have priority, requests only run in RUN.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         bank[sweep_addr] <= INIT_VALUE;
      end else if (wr_fire) begin
         bank[req_addr] <= merge_bytes(bank[req_addr], req_wdata, req_be);
      end
   end

   // Read pipeline: capture at accept, then shift; data only moves with a
   // valid so the output word holds until the next response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p <= '0;
         err_p <= '0;
         for (int k = 0; k < READ_LATENCY; k++) data_p[k] <= '0;
      end else begin
         vld_p[0] <= rd_fire;
         if (rd_fire) begin
            data_p[0] <= rd_word;
            err_p[0]  <= ~in_range;
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            vld_p[k] <= vld_p[k-1];
            if (vld_p[k-1]) begin
               data_p[k] <= data_p[k-1];
               err_p[k]  <= err_p[k-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_pipe.sv
// Self-checking bench for mem_pipe: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transaction-level model
// (word array + queue of expected responses with their due cycle).
module tb_mem_pipe;

   localparam int          TB_MEM  = 20;
   localparam int          TB_ADDR = 5;
   localparam int          TB_LAT  = 3;
   localparam logic [15:0] TB_INIT = 16'hC3A5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 clear;
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [TB_ADDR-1:0]   req_addr;
   logic [15:0]          req_wdata;
   logic [1:0]           req_be;
   logic                 rsp_valid;
   logic [15:0]          rsp_data;
   logic                 rsp_err;
   logic                 init_done;

   mem_pipe #(
      .WORD_SIZE    (16),
      .MEM_SIZE     (TB_MEM),
      .ADDR_SIZE    (TB_ADDR),
      .READ_LATENCY (TB_LAT),
      .INIT_VALUE   (TB_INIT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] data;
      logic        err;
   } rsp_t;

   // Reference model state
   logic [15:0] mem [TB_MEM];
   rsp_t        pend [$];
   bit          rdy;
   bit          drain;
   int          sweep_left;
   int          cyc;
   logic [15:0] last_data;
   bit          emitted;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: check outputs mid-cycle, then advance the model
   // through the rising edge using the inputs present at that edge.
   task automatic tick();
      rsp_t r;
      @(negedge clk);
      emitted = 0;
      if (!reset) begin
         check_val("rst_ready", {31'd0, req_ready}, 32'd0);
         check_val("rst_init_done", {31'd0, init_done}, 32'd0);
         check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
         check_val("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
      end else begin
         check_val("ready", {31'd0, req_ready}, {31'd0, rdy});
         check_val("init_done", {31'd0, init_done}, {31'd0, rdy});
         if (pend.size() > 0 && pend[0].due == cyc) begin
            check_val("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("rsp_data", {16'd0, rsp_data}, {16'd0, pend[0].data});
            check_val("rsp_err", {31'd0, rsp_err}, {31'd0, pend[0].err});
            last_data = pend[0].data;
            void'(pend.pop_front());
            emitted = 1;
         end else begin
            check_val("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
            check_val("rsp_hold", {16'd0, rsp_data}, {16'd0, last_data});
         end
      end
      @(posedge clk);
      cyc++;
      if (reset) begin
         if (rdy) begin
            if (req_valid) begin
               if (req_write) begin
                  if (int'(req_addr) < TB_MEM) begin
                     for (int b = 0; b < 2; b++)
                        if (req_be[b]) mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                  end
               end else begin
                  r.due  = cyc + TB_LAT - 1;
                  r.err  = (int'(req_addr) >= TB_MEM);
                  r.data = r.err ? 16'h0000 : mem[req_addr];
                  pend.push_back(r);
               end
            end
            if (clear) begin
               rdy   = 0;
               drain = 1;
            end
         end else if (drain) begin
            if (pend.size() == 0 && !emitted) begin
               drain      = 0;
               sweep_left = TB_MEM;
            end
         end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) begin
               rdy = 1;
               for (int i = 0; i < TB_MEM; i++) mem[i] = TB_INIT;
            end
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic w, input logic [TB_ADDR-1:0] a,
                        input logic [15:0] d, input logic [1:0] be, input logic clr);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      clear     = clr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, 16'h0000, 2'b00, 1'b0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      pend.delete();
      rdy        = 0;
      drain      = 0;
      sweep_left = TB_MEM;
      last_data  = 16'h0000;
      repeat (n) tick();
      reset = 1'b1;
   endtask

   task automatic read_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive(1'b1, 1'b0, TB_ADDR'(i), 16'h0000, 2'b00, 1'b0);
         tick();
      end
      idle();
      repeat (TB_LAT + 1) tick();
   endtask

   initial begin
      cyc = 0;
      idle();
      reset = 1'b0;
      @(posedge clk);
      #1;
      do_reset(3);

      // T1: sweep length, then every address returns the init word
      repeat (TB_MEM - 1) tick();
      check_val("t1_ready_low", {31'd0, req_ready}, 32'd0);
      tick();
      check_val("t1_ready_high", {31'd0, req_ready}, 32'd1);
      check_val("t1_init_done", {31'd0, init_done}, 32'd1);
      read_range(0, 31);

      // T2: partial byte write merges into the earlier full write
      drive(1'b1, 1'b1, 5'd3, 16'hBEEF, 2'b11, 1'b0); tick();
      drive(1'b1, 1'b1, 5'd3, 16'h1200, 2'b10, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd3, 16'h0000, 2'b00, 1'b0); tick();
      idle();
      repeat (TB_LAT - 1) tick();
      check_val("t2_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("t2_data", {16'd0, rsp_data}, 32'h12EF);
      repeat (2) tick();

      // T3: read right after write sees the new word
      drive(1'b1, 1'b1, 5'd7, 16'hA5A5, 2'b11, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd7, 16'h0000, 2'b00, 1'b0); tick();
      idle();
      repeat (TB_LAT - 1) tick();
      check_val("t3_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("t3_data", {16'd0, rsp_data}, 32'hA5A5);
      repeat (2) tick();

      // T4: back-to-back reads of 0..4
      read_range(0, 4);

      // T5: out-of-range write dropped, read flagged, alias untouched
      drive(1'b1, 1'b1, 5'd25, 16'h1234, 2'b11, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd25, 16'h0000, 2'b00, 1'b0); tick();
      idle();
      repeat (TB_LAT - 1) tick();
      check_val("t5_err", {31'd0, rsp_err}, 32'd1);
      check_val("t5_data", {16'd0, rsp_data}, 32'h0000);
      repeat (2) tick();
      drive(1'b1, 1'b0, 5'd5, 16'h0000, 2'b00, 1'b0); tick();
      idle();
      repeat (TB_LAT - 1) tick();
      check_val("t5_alias", {16'd0, rsp_data}, {16'd0, TB_INIT});
      check_val("t5_alias_err", {31'd0, rsp_err}, 32'd0);
      repeat (2) tick();

      // T6: clear with two reads in flight, then a full re-sweep
      drive(1'b1, 1'b0, 5'd3, 16'h0000, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd7, 16'h0000, 2'b00, 1'b1); tick();
      idle();
      check_val("t6_ready_drop", {31'd0, req_ready}, 32'd0);
      repeat (TB_LAT + TB_MEM + 4) tick();
      check_val("t6_ready_back", {31'd0, req_ready}, 32'd1);
      read_range(0, TB_MEM - 1);

      // T6b: reset in the middle of a sweep, and with reads in flight
      drive(1'b1, 1'b1, 5'd9, 16'h7777, 2'b11, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd9, 16'h0000, 2'b00, 1'b1); tick();
      idle();
      repeat (TB_LAT + 6) tick();
      do_reset(2);
      repeat (TB_MEM + 2) tick();
      drive(1'b1, 1'b0, 5'd9, 16'h0000, 2'b00, 1'b0); tick();
      drive(1'b1, 1'b0, 5'd1, 16'h0000, 2'b00, 1'b0); tick();
      do_reset(2);
      idle();
      repeat (TB_MEM + 2) tick();
      read_range(8, 10);

      // Randomized traffic with occasional clear and reset
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom % 4) != 0,
               ($urandom % 2) == 1,
               ($urandom % 2 == 1) ? TB_ADDR'($urandom % 8) : TB_ADDR'($urandom % 32),
               16'($urandom),
               2'($urandom),
               ($urandom % 80) == 0);
         if ($urandom % 1200 == 0) begin
            idle();
            do_reset(2);
         end else begin
            tick();
         end
      end
      idle();
      repeat (TB_MEM + TB_LAT + 8) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
